// File: rtl/bp_resolve_queue_if.sv
// Prediction and resolution channels between fetch/EX and the resolve queue.
// Handshake: a prediction transfers on a rising clk_i edge where pred_valid_i && pred_ready_o; ex_valid_i is a one-cycle strobe with no back-pressure.
interface bp_resolve_queue_if;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;

    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        ex_compressed_i;

    logic        ex_br_valid_o;
    logic [31:0] ex_br_instr_addr_o;
    logic        ex_br_taken_o;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;

    modport master (
        output pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
        output ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i, ex_compressed_i,
        input  pred_ready_o,
        input  ex_br_valid_o, ex_br_instr_addr_o, ex_br_taken_o, mispredict_o, redirect_pc_o
    );

    modport slave (
        input  pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
        input  ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i, ex_compressed_i,
        output pred_ready_o,
        output ex_br_valid_o, ex_br_instr_addr_o, ex_br_taken_o, mispredict_o, redirect_pc_o
    );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-stage predictions, matched against EX resolutions to
// produce predictor training, mispredict redirects and performance counters.
module bp_resolve_queue #(
    parameter int Depth = 4,
    parameter int CntW  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     kill_i,
    bp_resolve_queue_if.slave        bus,
    output logic [$clog2(Depth):0]   count_o,
    output logic [CntW-1:0]          branch_cnt_o,
    output logic [CntW-1:0]          mispredict_cnt_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int OccW = PtrW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t            mem_q [Depth];
    entry_t            mem_d [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]   count_q, count_d;

    logic              br_valid_q, br_valid_d;
    logic [31:0]       br_addr_q, br_addr_d;
    logic              br_taken_q, br_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [31:0]       redirect_q, redirect_d;
    logic [CntW-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CntW-1:0]   misp_cnt_q, misp_cnt_d;

    entry_t            head;
    logic              pred_ready;
    logic              resolve;
    logic              hit;
    logic              eff_taken;
    logic [31:0]       eff_target;
    logic              mispredict;
    logic              push;
    logic              pop;
    logic [31:0]       fallthru_pc;

    // Ready looks only at registered occupancy; a same-cycle pop never frees a slot early.
    assign pred_ready = !rst_i && (count_q < OccW'(Depth));
    assign head       = mem_q[rd_ptr_q];

    assign resolve    = bus.ex_valid_i && !kill_i;
    assign hit        = resolve && (count_q != '0) && (head.pc == bus.ex_pc_i);
    assign eff_taken  = hit && head.taken;
    assign eff_target = hit ? head.target : 32'h0;

    // An unmatched resolution is judged against an implicit not-taken prediction.
    assign mispredict = resolve &&
                        ((bus.ex_taken_i != eff_taken) ||
                         (bus.ex_taken_i && eff_taken && (bus.ex_target_i != eff_target)));

    assign pop         = hit && !mispredict;
    assign push        = bus.pred_valid_i && pred_ready && !kill_i && !mispredict;
    assign fallthru_pc = bus.ex_pc_i + (bus.ex_compressed_i ? 32'd2 : 32'd4);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (kill_i || mispredict) begin
            // Everything still queued is on the wrong path; restart the ring from slot 0.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc:     bus.pred_pc_i,
                                    taken:  bus.pred_taken_i,
                                    target: bus.pred_target_i};
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + OccW'(push) - OccW'(pop);
        end
    end

    always_comb begin
        br_valid_d   = resolve;
        br_addr_d    = br_addr_q;
        br_taken_d   = br_taken_q;
        mispredict_d = mispredict;
        redirect_d   = redirect_q;
        branch_cnt_d = branch_cnt_q;
        misp_cnt_d   = misp_cnt_q;

        if (resolve) begin
            br_addr_d  = bus.ex_pc_i;
            br_taken_d = bus.ex_taken_i;
            if (branch_cnt_q != {CntW{1'b1}}) begin
                branch_cnt_d = branch_cnt_q + CntW'(1);
            end
        end
        if (mispredict) begin
            redirect_d = bus.ex_taken_i ? bus.ex_target_i : fallthru_pc;
            if (misp_cnt_q != {CntW{1'b1}}) begin
                misp_cnt_d = misp_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            br_valid_q   <= 1'b0;
            br_addr_q    <= '0;
            br_taken_q   <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            br_valid_q   <= br_valid_d;
            br_addr_q    <= br_addr_d;
            br_taken_q   <= br_taken_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end

    assign bus.pred_ready_o       = pred_ready;
    assign bus.ex_br_valid_o      = br_valid_q;
    assign bus.ex_br_instr_addr_o = br_addr_q;
    assign bus.ex_br_taken_o      = br_taken_q;
    assign bus.mispredict_o       = mispredict_q;
    assign bus.redirect_pc_o      = redirect_q;
    assign count_o                = count_q;
    assign branch_cnt_o           = branch_cnt_q;
    assign mispredict_cnt_o       = misp_cnt_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: directed scenarios plus randomized traffic against
// a queue-based reference model; narrow counters so saturation is reached.
module tb_bp_resolve_queue;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int OCCW  = $clog2(DEPTH) + 1;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic kill_i = 1'b0;
    logic [OCCW-1:0] count_o;
    logic [CNTW-1:0] branch_cnt_o;
    logic [CNTW-1:0] mispredict_cnt_o;

    bp_resolve_queue_if bus ();

    bp_resolve_queue #(.Depth(DEPTH), .CntW(CNTW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .kill_i           (kill_i),
        .bus              (bus),
        .count_o          (count_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_t;

    pred_t           mq[$];
    logic            m_br_valid;
    logic [31:0]     m_addr;
    logic            m_taken;
    logic            m_misp;
    logic [31:0]     m_redir;
    logic [CNTW-1:0] m_bcnt;
    logic [CNTW-1:0] m_mcnt;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        mq.delete();
        m_br_valid = 0; m_addr = 0; m_taken = 0; m_misp = 0; m_redir = 0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit          accept;
        bit          matched;
        logic        p_taken;
        logic [31:0] p_target;
        bit          wrong;
        pred_t       e;
        if (rst_i) begin
            model_reset();
            return;
        end
        accept = bus.pred_valid_i && (mq.size() < DEPTH);
        if (kill_i) begin
            mq.delete();
            m_br_valid = 0;
            m_misp = 0;
            return;
        end
        m_br_valid = 0;
        m_misp = 0;
        if (bus.ex_valid_i) begin
            matched  = (mq.size() > 0) && (mq[0].pc == bus.ex_pc_i);
            p_taken  = matched ? mq[0].taken : 1'b0;
            p_target = matched ? mq[0].target : 32'h0;
            wrong = (bus.ex_taken_i != p_taken) ||
                    (bus.ex_taken_i && p_taken && bus.ex_target_i != p_target);
            m_br_valid = 1;
            m_addr  = bus.ex_pc_i;
            m_taken = bus.ex_taken_i;
            m_misp  = wrong;
            if (m_bcnt != CNT_MAX) m_bcnt = m_bcnt + 1'b1;
            if (wrong) begin
                if (m_mcnt != CNT_MAX) m_mcnt = m_mcnt + 1'b1;
                m_redir = bus.ex_taken_i ? bus.ex_target_i
                                         : bus.ex_pc_i + (bus.ex_compressed_i ? 32'd2 : 32'd4);
                mq.delete();
                accept = 0;
            end else if (matched) begin
                void'(mq.pop_front());
            end
        end
        if (accept) begin
            e.pc = bus.pred_pc_i; e.taken = bus.pred_taken_i; e.target = bus.pred_target_i;
            mq.push_back(e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        kill_i = 0;
        bus.pred_valid_i = 0; bus.pred_pc_i = 0; bus.pred_taken_i = 0; bus.pred_target_i = 0;
        bus.ex_valid_i = 0; bus.ex_pc_i = 0; bus.ex_taken_i = 0; bus.ex_target_i = 0;
        bus.ex_compressed_i = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        bus.pred_valid_i = 1; bus.pred_pc_i = pc; bus.pred_taken_i = taken; bus.pred_target_i = target;
        tick();
        bus.pred_valid_i = 0;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                               input logic compressed);
        bus.ex_valid_i = 1; bus.ex_pc_i = pc; bus.ex_taken_i = taken; bus.ex_target_i = target;
        bus.ex_compressed_i = compressed;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        #1;
        tests++; if (bus.pred_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got=%0b exp=0", bus.pred_ready_o); end
        tick();
        tick();
        tests++; if (bus.pred_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready_hold got=%0b exp=0", bus.pred_ready_o); end
        tests++;
        if ({bus.ex_br_valid_o, bus.ex_br_taken_o, bus.mispredict_o} !== 3'b000 ||
            bus.ex_br_instr_addr_o !== 32'h0 || bus.redirect_pc_o !== 32'h0 ||
            count_o !== '0 || branch_cnt_o !== '0 || mispredict_cnt_o !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%0b a=%h t=%0b m=%0b r=%h c=%0d b=%0d mc=%0d exp all 0",
                     bus.ex_br_valid_o, bus.ex_br_instr_addr_o, bus.ex_br_taken_o, bus.mispredict_o,
                     bus.redirect_pc_o, count_o, branch_cnt_o, mispredict_cnt_o);
        end
        rst_i = 0;
        #1;
        tests++; if (bus.pred_ready_o !== 1'b1) begin fails++; $display("FAIL release_ready got=%0b exp=1", bus.pred_ready_o); end
    endtask

    task automatic test_correct_predict();
        do_reset();
        push(32'h100, 1, 32'h140);
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL correct_push_count got=%0d exp=1", count_o); end
        set_resolve(32'h100, 1, 32'h140, 0);
        tick();
        clear_inputs();
        tests++;
        if (bus.ex_br_valid_o !== 1'b1 || bus.ex_br_instr_addr_o !== 32'h100 || bus.ex_br_taken_o !== 1'b1) begin
            fails++;
            $display("FAIL correct_train got v=%0b a=%h t=%0b exp v=1 a=100 t=1",
                     bus.ex_br_valid_o, bus.ex_br_instr_addr_o, bus.ex_br_taken_o);
        end
        tests++;
        if (bus.mispredict_o !== 1'b0 || count_o !== 3'd0 || branch_cnt_o !== 4'd1) begin
            fails++;
            $display("FAIL correct_state got m=%0b c=%0d b=%0d exp m=0 c=0 b=1",
                     bus.mispredict_o, count_o, branch_cnt_o);
        end
        tick();
        tests++; if (bus.ex_br_valid_o !== 1'b0) begin fails++; $display("FAIL correct_pulse got=%0b exp=0", bus.ex_br_valid_o); end
    endtask

    task automatic test_mispredict_flush();
        do_reset();
        push(32'h100, 1, 32'h140);
        push(32'h104, 0, 32'h0);
        push(32'h108, 1, 32'h180);
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL flush_fill got=%0d exp=3", count_o); end
        set_resolve(32'h100, 0, 32'h0, 1);
        bus.pred_valid_i = 1; bus.pred_pc_i = 32'h10C; bus.pred_taken_i = 0; bus.pred_target_i = 0;
        tick();
        clear_inputs();
        tests++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h102) begin
            fails++;
            $display("FAIL flush_redirect got m=%0b r=%h exp m=1 r=102", bus.mispredict_o, bus.redirect_pc_o);
        end
        tests++;
        if (count_o !== 3'd0 || mispredict_cnt_o !== 4'd1) begin
            fails++;
            $display("FAIL flush_state got c=%0d mc=%0d exp c=0 mc=1", count_o, mispredict_cnt_o);
        end
        tick();
        tests++;
        if (bus.mispredict_o !== 1'b0 || count_o !== 3'd0 || bus.redirect_pc_o !== 32'h102) begin
            fails++;
            $display("FAIL flush_after got m=%0b c=%0d r=%h exp m=0 c=0 r=102",
                     bus.mispredict_o, count_o, bus.redirect_pc_o);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'h300 + 32'(4 * i), 0, 32'h0);
        #1;
        tests++; if (bus.pred_ready_o !== 1'b0 || count_o !== 3'd4) begin
            fails++; $display("FAIL full_ready got rdy=%0b c=%0d exp rdy=0 c=4", bus.pred_ready_o, count_o);
        end
        bus.pred_valid_i = 1; bus.pred_pc_i = 32'h400; bus.pred_taken_i = 0; bus.pred_target_i = 0;
        set_resolve(32'h300, 0, 32'h0, 0);
        tick();
        clear_inputs();
        #1;
        tests++; if (count_o !== 3'd3 || bus.mispredict_o !== 1'b0) begin
            fails++; $display("FAIL full_pop got c=%0d m=%0b exp c=3 m=0", count_o, bus.mispredict_o);
        end
        tests++; if (bus.pred_ready_o !== 1'b1) begin fails++; $display("FAIL full_ready_after got=%0b exp=1", bus.pred_ready_o); end
        for (int i = 1; i < DEPTH; i++) begin
            set_resolve(32'h300 + 32'(4 * i), 0, 32'h0, 0);
            tick();
            clear_inputs();
            tests++; if (bus.mispredict_o !== 1'b0) begin fails++; $display("FAIL full_drain_%0d got m=1 exp m=0", i); end
        end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL full_dropped_push got c=%0d exp 0", count_o); end
    endtask

    task automatic test_empty_resolve();
        do_reset();
        set_resolve(32'h200, 1, 32'h240, 0);
        tick();
        clear_inputs();
        tests++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h240 || count_o !== 3'd0) begin
            fails++;
            $display("FAIL empty_resolve got m=%0b r=%h c=%0d exp m=1 r=240 c=0",
                     bus.mispredict_o, bus.redirect_pc_o, count_o);
        end
    endtask

    task automatic test_kill();
        do_reset();
        push(32'h500, 1, 32'h540);
        push(32'h504, 1, 32'h540);
        kill_i = 1;
        set_resolve(32'h500, 0, 32'h0, 0);
        bus.pred_valid_i = 1; bus.pred_pc_i = 32'h508;
        tick();
        clear_inputs();
        tests++;
        if (count_o !== 3'd0 || bus.ex_br_valid_o !== 1'b0 || bus.mispredict_o !== 1'b0) begin
            fails++;
            $display("FAIL kill_flush got c=%0d v=%0b m=%0b exp 0 0 0", count_o, bus.ex_br_valid_o, bus.mispredict_o);
        end
        tests++;
        if (branch_cnt_o !== 4'd0 || mispredict_cnt_o !== 4'd0) begin
            fails++;
            $display("FAIL kill_counters got b=%0d mc=%0d exp 0 0", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(32'h600, 0, 32'h0);
        push(32'h604, 1, 32'h680);
        set_resolve(32'h600, 0, 32'h0, 0);
        tick();
        tests++;
        if (bus.ex_br_valid_o !== 1'b1 || bus.ex_br_instr_addr_o !== 32'h600 || bus.mispredict_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first got v=%0b a=%h m=%0b exp 1 600 0",
                     bus.ex_br_valid_o, bus.ex_br_instr_addr_o, bus.mispredict_o);
        end
        set_resolve(32'h604, 1, 32'h680, 0);
        tick();
        clear_inputs();
        tests++;
        if (bus.ex_br_valid_o !== 1'b1 || bus.ex_br_instr_addr_o !== 32'h604 || bus.ex_br_taken_o !== 1'b1 ||
            bus.mispredict_o !== 1'b0 || count_o !== 3'd0 || branch_cnt_o !== 4'd2) begin
            fails++;
            $display("FAIL b2b_second got v=%0b a=%h t=%0b m=%0b c=%0d b=%0d exp 1 604 1 0 0 2",
                     bus.ex_br_valid_o, bus.ex_br_instr_addr_o, bus.ex_br_taken_o, bus.mispredict_o,
                     count_o, branch_cnt_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst_i  = ($urandom_range(0, 199) == 0);
            kill_i = ($urandom_range(0, 39) == 0);
            bus.pred_valid_i  = ($urandom_range(0, 2) != 0);
            bus.pred_pc_i     = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            bus.pred_taken_i  = 1'($urandom_range(0, 1));
            bus.pred_target_i = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            bus.ex_valid_i    = ($urandom_range(0, 1) == 0);
            bus.ex_compressed_i = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
                bus.ex_pc_i     = mq[0].pc;
                bus.ex_taken_i  = ($urandom_range(0, 5) != 0) ? mq[0].taken : !mq[0].taken;
                bus.ex_target_i = ($urandom_range(0, 5) != 0) ? mq[0].target
                                                              : 32'h2000 + 32'(4 * $urandom_range(0, 3));
            end else begin
                bus.ex_pc_i     = 32'h1000 + 32'(4 * $urandom_range(0, 7));
                bus.ex_taken_i  = 1'($urandom_range(0, 1));
                bus.ex_target_i = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            end
            #1;
            tests++;
            if (bus.pred_ready_o !== (!rst_i && mq.size() < DEPTH)) begin
                fails++; $display("FAIL rand_ready cyc=%0d got=%0b", c, bus.pred_ready_o);
            end
            tick();
            tests++;
            if (bus.ex_br_valid_o !== m_br_valid || bus.ex_br_instr_addr_o !== m_addr ||
                bus.ex_br_taken_o !== m_taken || bus.mispredict_o !== m_misp || bus.redirect_pc_o !== m_redir) begin
                fails++;
                $display("FAIL rand_outputs cyc=%0d got v=%0b a=%h t=%0b m=%0b r=%h exp v=%0b a=%h t=%0b m=%0b r=%h",
                         c, bus.ex_br_valid_o, bus.ex_br_instr_addr_o, bus.ex_br_taken_o, bus.mispredict_o,
                         bus.redirect_pc_o, m_br_valid, m_addr, m_taken, m_misp, m_redir);
            end
            tests++;
            if (count_o !== OCCW'(mq.size()) || branch_cnt_o !== m_bcnt || mispredict_cnt_o !== m_mcnt) begin
                fails++;
                $display("FAIL rand_state cyc=%0d got c=%0d b=%0d mc=%0d exp c=%0d b=%0d mc=%0d",
                         c, count_o, branch_cnt_o, mispredict_cnt_o, mq.size(), m_bcnt, m_mcnt);
            end
        end
        clear_inputs();
        rst_i = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        test_reset();
        test_correct_predict();
        test_mispredict_flush();
        test_full();
        test_empty_resolve();
        test_kill();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
